nrisc_ula_arbiter: RTL
======================

Name: nrisc_ula_arbiter

Overview:
- Shares one registered NRISC ULA instance between two requesters (e.g. integer pipe and address/branch unit).
- Arbitrates with round-robin priority and drives the ULA operand/control inputs from internal holding registers.
- Sequences the ULA's one-cycle registered latency, then returns result and flags over a single valid/ready response channel tagged with the requester id.
- Instantiated by the parent next to the ULA; the ULA is not instantiated inside this block.

Parameters:
TAM, 32, datapath width of operands and result (must match the ULA's TAM)
CNT_W, 16, width of the grant counters (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_ctrl  in  4  ULA control for requester 0
req0_a  in  TAM  operand A for requester 0
req0_b  in  TAM  operand B for requester 0
req1_valid  in  1  requester 1 has an operation
req1_ready  out  1  requester 1 operation accepted this cycle
req1_ctrl  in  4  ULA control for requester 1
req1_a  in  TAM  operand A for requester 1
req1_b  in  TAM  operand B for requester 1
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_id  out  1  requester that owns the result (0/1)
rsp_out  out  TAM  captured ULA result
rsp_flags  out  3  captured ULA flags {minus, zero, carry}
ula_a  out  TAM  to ULA input A
ula_b  out  TAM  to ULA input B
ula_ctrl  out  4  to ULA control
ula_out  in  TAM  from ULA registered output
ula_flags  in  3  from ULA registered flags
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; last_grant=1, so requester 0 wins the first tie.
- States: IDLE, EXEC, CAPT, RESP.
- Arbitration (IDLE, or RESP during the handshake cycle):
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - Winner's reqN_ready=1 for exactly that cycle (combinational, depends on valid). The loser's ready stays 0.
- Accept edge:
  - Latch winner's ctrl/a/b into the holding regs that drive ula_ctrl/ula_a/ula_b.
  - Latch rsp_id and set last_grant=winner.
  - Go to EXEC.
- EXEC: holding regs stable; ULA samples at the end-of-cycle edge; go to CAPT.
- CAPT: ula_out/ula_flags now reflect the op; at the end-of-cycle edge capture them into rsp_out/rsp_flags, set rsp_valid=1, go to RESP.
- RESP: rsp_valid held with rsp_out/rsp_flags/rsp_id stable until rsp_ready=1. On the handshake edge:
  - If any reqN_valid is high, accept per the arbitration rules in the same cycle and go to EXEC (rsp_valid drops).
  - Otherwise go to IDLE.
- Latency: accept edge E0 → rsp_valid high after E2. Peak throughput 1 op per 3 cycles.
- Holding regs keep their last values in IDLE (no toggling of ula_* while idle).
- A request is never accepted in EXEC or CAPT. A valid requester must hold its inputs stable until ready.
- rsp_ready held low indefinitely: stays in RESP, no new accepts, both readys 0.
- Flags are passed through unmodified; the block does not interpret ctrl.
- rst asserted mid-operation: the in-flight op is discarded, no response is produced, outputs return to reset values immediately.

Optional Feature:
NRISC_ULA_ARB_CNT_EN
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (CNT_W each).
  - Each increments on every accept edge of its requester, saturating at all-ones.
  - Reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset release, req0 only: ctrl=4'h0, a=5, b=7, rsp_ready=1 → req0_ready 1 cycle, rsp_valid exactly 2 edges later, rsp_out=12, rsp_id=0, rsp_flags=3'b000, busy 1 from accept until handshake.
- Both valid continuously, ctrl=4'h4 (OR), a/b distinct per requester, rsp_ready=1 → grants alternate 0,1,0,1; each rsp_out matches the owner's a|b; a new accept occurs on each handshake cycle (3-cycle spacing).
- Backpressure: single op, rsp_ready=0 for 5 cycles → rsp_valid/out/id stable, req1_valid=1 meanwhile gets no ready; rsp_ready=1 → req1 accepted on the same edge.
- Zero flag: ctrl=4'h6 (XOR), a=b=32'hDEADBEEF → rsp_out=0, rsp_flags[1]=1.
- rst pulse asserted during CAPT → immediately state IDLE, rsp_valid=0, ula_* =0; after release, a fresh req0 op completes normally with correct result.
- With NRISC_ULA_ARB_CNT_EN and CNT_W=2: 5 req0 grants → grant_cnt0=3 (saturated), grant_cnt1=0.

Source files
------------

// File: rtl/nrisc_ula_arbiter.sv
// nrisc_ula_arbiter: shares one registered NRISC ULA between two requesters.
// Round-robin arbitration, operands held in registers that drive the ULA,
// one-cycle ULA latency sequenced before a tagged valid/ready response.
// Optional grant counters are enabled by defining NRISC_ULA_ARB_CNT_EN.
module nrisc_ula_arbiter #(
  parameter int unsigned TAM   = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [3:0]     req0_ctrl,
  input  logic [TAM-1:0] req0_a,
  input  logic [TAM-1:0] req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [3:0]     req1_ctrl,
  input  logic [TAM-1:0] req1_a,
  input  logic [TAM-1:0] req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [TAM-1:0] rsp_out,
  output logic [2:0]     rsp_flags,
  output logic [TAM-1:0] ula_a,
  output logic [TAM-1:0] ula_b,
  output logic [3:0]     ula_ctrl,
  input  logic [TAM-1:0] ula_out,
  input  logic [2:0]     ula_flags,
  output logic           busy
`ifdef NRISC_ULA_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  typedef enum logic [1:0] {StIdle, StExec, StCapt, StResp} state_e;

  state_e state_q;
  logic   last_grant_q;
  logic   arb_open;
  logic   win0;
  logic   win1;
  logic   accept;
  logic   grant;

  // Arbitration window and round-robin winner selection
  always_comb begin
    arb_open = !rst && ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
    win0     = req0_valid && (!req1_valid || last_grant_q);
    win1     = req1_valid && (!req0_valid || !last_grant_q);
  end

  assign req0_ready = arb_open && win0;
  assign req1_ready = arb_open && win1;
  assign accept     = req0_ready || req1_ready;
  assign grant      = req1_ready;
  assign busy       = (state_q != StIdle);

  // Sequencer: accept, wait out ULA latency, capture, hold response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      ula_a        <= '0;
      ula_b        <= '0;
      ula_ctrl     <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_out      <= '0;
      rsp_flags    <= '0;
    end else begin
      // accept can only be high in StIdle or on the StResp handshake
      if (accept) begin
        ula_a        <= grant ? req1_a : req0_a;
        ula_b        <= grant ? req1_b : req0_b;
        ula_ctrl     <= grant ? req1_ctrl : req0_ctrl;
        rsp_id       <= grant;
        last_grant_q <= grant;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) state_q <= StExec;
        end
        StExec: begin
          state_q <= StCapt;
        end
        StCapt: begin
          rsp_out   <= ula_out;
          rsp_flags <= ula_flags;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= accept ? StExec : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef NRISC_ULA_ARB_CNT_EN
  // Saturating per-requester grant counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && (grant_cnt0 != {CNT_W{1'b1}})) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (req1_ready && (grant_cnt1 != {CNT_W{1'b1}})) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end
`else
  // CNT_W only sizes the grant counters
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W == 0);
`endif

endmodule
